// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter: round-robin sharing of a two-digit seven-segment display
// with a minimum hold time per shown value and a free-running display strobe.
module seg_display_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int HOLD_CYCLES = 1000,
  parameter int EN_DIV      = 4,
  parameter int CNT_W       = 16,
  localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [ID_W-1:0]      active_id,
  output logic [7:0]           disp_data,
  output logic                 disp_en,
  output logic                 busy
);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t state, state_nx;
  logic [ID_W-1:0]  ptr, win, ptr_nx;
  logic [ID_W:0]    cand;
  logic [CNT_W-1:0] cnt, pre;
  logic             found, arb;
  // Scan upward from ptr with wrap; the extra bit keeps ptr+k from overflowing
  always_comb begin
    win   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ)) cand = cand - (ID_W+1)'(NUM_REQ);
      if (!found && req[cand[ID_W-1:0]]) begin
        found = 1'b1;
        win   = cand[ID_W-1:0];
      end
    end
    ptr_nx = (win == ID_W'(NUM_REQ-1)) ? '0 : win + 1'b1;
  end
  always_comb begin
    arb      = found && (state == IDLE || cnt == '0);
    state_nx = arb ? HOLD : (state == HOLD && cnt == '0) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt       <= '0;
      active_id <= '0;
      disp_data <= 8'h00;
      busy      <= 1'b0;
      ptr       <= '0;
      cnt       <= '0;
    end else begin
      gnt  <= arb ? (NUM_REQ'(1) << win) : '0;
      busy <= (state_nx == HOLD);
      if (arb) begin
        active_id <= win;
        disp_data <= req_data[{win, 3'b000} +: 8];
        ptr       <= ptr_nx;
        cnt       <= CNT_W'(HOLD_CYCLES-1);
      end else if (state == HOLD && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end
  // Strobe fires the cycle after the prescaler wraps, independent of arbitration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre     <= '0;
      disp_en <= 1'b0;
    end else begin
      pre     <= (pre == CNT_W'(EN_DIV-1)) ? '0 : pre + 1'b1;
      disp_en <= (pre == CNT_W'(EN_DIV-1));
    end
  end
endmodule

// File: tb/tb_seg_display_arbiter.sv
// tb_seg_display_arbiter: two arbiter configurations driven side by side and
// compared cycle by cycle with a time-since-last-grant reference model.
module tb_seg_display_arbiter;
  localparam int NA = 4, HA = 4, EA = 4;
  localparam int NB = 3, HB = 1, EB = 1;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [7:0]  rq [2];
  logic [63:0] dt [2];
  logic [NA-1:0] gnt_a; logic [1:0] id_a; logic [7:0] disp_a; logic en_a, busy_a;
  logic [NB-1:0] gnt_b; logic [1:0] id_b; logic [7:0] disp_b; logic en_b, busy_b;
  seg_display_arbiter #(.NUM_REQ(NA), .HOLD_CYCLES(HA), .EN_DIV(EA), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(rq[0][NA-1:0]), .req_data(dt[0][8*NA-1:0]),
    .gnt(gnt_a), .active_id(id_a), .disp_data(disp_a), .disp_en(en_a), .busy(busy_a));
  seg_display_arbiter #(.NUM_REQ(NB), .HOLD_CYCLES(HB), .EN_DIV(EB), .CNT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(rq[1][NB-1:0]), .req_data(dt[1][8*NB-1:0]),
    .gnt(gnt_b), .active_id(id_b), .disp_data(disp_b), .disp_en(en_b), .busy(busy_b));
  int nreq [2], hold [2], ediv [2];
  int ecount, last_g [2], ptr [2];
  bit have_g [2];
  logic [7:0] x_gnt [2], x_id [2], x_data [2];
  logic       x_en [2], x_busy [2];
  int checks = 0, fails = 0;
  task automatic chk(input string tag, input int i, input logic [7:0] obs, input logic [7:0] ex);
    checks++;
    assert (obs === ex) else begin
      fails++;
      $error("FAIL %s[%0d] t=%0t observed=%0h expected=%0h", tag, i, $time, obs, ex);
    end
  endtask
  task automatic check_all();
    chk("gnt",  0, 8'(gnt_a), x_gnt[0]);
    chk("id",   0, 8'(id_a),  x_id[0]);
    chk("data", 0, disp_a,    x_data[0]);
    chk("en",   0, 8'(en_a),  8'(x_en[0]));
    chk("busy", 0, 8'(busy_a), 8'(x_busy[0]));
    chk("gnt",  1, 8'(gnt_b), x_gnt[1]);
    chk("id",   1, 8'(id_b),  x_id[1]);
    chk("data", 1, disp_b,    x_data[1]);
    chk("en",   1, 8'(en_b),  8'(x_en[1]));
    chk("busy", 1, 8'(busy_b), 8'(x_busy[1]));
  endtask
  task automatic model_reset();
    ecount = 0;
    for (int i = 0; i < 2; i++) begin
      have_g[i] = 1'b0; last_g[i] = 0; ptr[i] = 0;
      x_gnt[i] = '0; x_id[i] = '0; x_data[i] = '0; x_en[i] = 1'b0; x_busy[i] = 1'b0;
    end
  endtask
  // A grant may happen once HOLD cycles have elapsed since the last one
  task automatic model_edge();
    ecount++;
    for (int i = 0; i < 2; i++) begin
      x_en[i]  = (ecount % ediv[i]) == 0;
      x_gnt[i] = '0;
      if ((!have_g[i] || ecount - last_g[i] >= hold[i]) && rq[i] != 0) begin
        int w;
        w = -1;
        for (int k = 0; k < nreq[i]; k++)
          if (w < 0 && rq[i][(ptr[i] + k) % nreq[i]]) w = (ptr[i] + k) % nreq[i];
        x_gnt[i]  = 8'(1) << w;
        x_id[i]   = 8'(w);
        x_data[i] = dt[i][8*w +: 8];
        ptr[i]    = (w + 1) % nreq[i];
        have_g[i] = 1'b1;
        last_g[i] = ecount;
      end
      x_busy[i] = have_g[i] && (ecount - last_g[i] < hold[i]);
    end
  endtask
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
  endtask
  initial begin
    nreq = '{NA, NB}; hold = '{HA, HB}; ediv = '{EA, EB};
    rq = '{8'h0, 8'h0};
    dt = '{64'h0, 64'h0};
    do_reset();
    rq[0] = 8'b0010; dt[0] = 64'h0000_0000_0000_5A00;
    step();
    rq[0] = 8'h0;
    for (int n = 0; n < 6; n++) step();
    rq[0] = 8'hF; dt[0] = 64'h0000_0000_1312_1110;
    rq[1] = 8'b101; dt[1] = 64'h0000_0000_00C2_B1A0;
    for (int n = 0; n < 22; n++) step();
    rq[0] = 8'b0001;
    step(); step();
    rq[0] = 8'b0101;
    for (int n = 0; n < 10; n++) step();
    for (int it = 0; it < 800; it++) begin
      if (it == 300 || it == 600) do_reset();
      for (int i = 0; i < 2; i++) begin
        rq[i] = (rq[i] ^ 8'($urandom & $urandom)) & 8'((1 << nreq[i]) - 1);
        dt[i] = {$urandom, $urandom};
      end
      if (it % 97 < 10) rq = '{8'h0, 8'h0};
      step();
    end
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
